// File: rtl/data_mem_responder_pkg.sv
// Shared encodings for the data-memory responder: RV32I access sizes and FSM states.
package mem_defs;

  localparam logic [2:0] SZ_B  = 3'b000;
  localparam logic [2:0] SZ_H  = 3'b001;
  localparam logic [2:0] SZ_W  = 3'b010;
  localparam logic [2:0] SZ_BU = 3'b100;
  localparam logic [2:0] SZ_HU = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WAIT   = 2'd1,
    ST_ACCESS = 2'd2,
    ST_RESP   = 2'd3
  } state_t;

endpackage

// File: rtl/data_mem_responder_if.sv
// Request/response bus between the CPU MEM stage (master) and the data-memory responder (slave).
interface data_mem_responder_if;
    // A request is taken on a rising edge where iReq && oReady; the payload only has to be
    // valid on that edge. Each accepted request gets exactly one oRValid pulse, and oRData/oErr
    // are meaningful only while oRValid is high.
    logic        iReq;
    logic        oReady;
    logic        iWrite;
    logic [31:0] iAddr;
    logic [31:0] iWData;
    logic [2:0]  iSize;
    logic        oRValid;
    logic [31:0] oRData;
    logic        oErr;
    logic        oBusy;

    modport master (
        output iReq, iWrite, iAddr, iWData, iSize,
        input  oReady, oRValid, oRData, oErr, oBusy
    );

    modport slave (
        input  iReq, iWrite, iAddr, iWData, iSize,
        output oReady, oRValid, oRData, oErr, oBusy
    );
endinterface

// File: rtl/data_mem_responder_lane_align.sv
// Byte-lane steering for RV32I loads/stores. Macro DMEM_MISALIGN_TRAP_EN turns misaligned H/W
// accesses into errors; without it the low address bits are forced to alignment.
module mem_lane_align
    import mem_defs::*;
(
    input  logic [2:0]  size,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] wdata,
    input  logic [31:0] rword,
    output logic [3:0]  lane_we,
    output logic [31:0] wdata_lanes,
    output logic [31:0] rdata_ext,
    output logic        err
);

    logic        half_mis;
    logic        word_mis;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
`ifdef DMEM_MISALIGN_TRAP_EN
        half_mis = addr_lo[0];
        word_mis = (addr_lo != 2'b00);
`else
        half_mis = 1'b0;
        word_mis = 1'b0;
`endif
        byte_sel    = rword[{addr_lo, 3'b000} +: 8];
        half_sel    = addr_lo[1] ? rword[31:16] : rword[15:0];
        lane_we     = 4'b0000;
        wdata_lanes = 32'h0;
        rdata_ext   = 32'h0;
        err         = 1'b0;

        case (size)
            SZ_B, SZ_BU: begin
                lane_we     = 4'b0001 << addr_lo;
                wdata_lanes = {4{wdata[7:0]}};
                rdata_ext   = (size == SZ_B) ? {{24{byte_sel[7]}}, byte_sel} : {24'h0, byte_sel};
            end
            SZ_H, SZ_HU: begin
                if (half_mis) begin
                    err = 1'b1;
                end else begin
                    lane_we     = addr_lo[1] ? 4'b1100 : 4'b0011;
                    wdata_lanes = {2{wdata[15:0]}};
                    rdata_ext   = (size == SZ_H) ? {{16{half_sel[15]}}, half_sel} : {16'h0, half_sel};
                end
            end
            SZ_W: begin
                if (word_mis) begin
                    err = 1'b1;
                end else begin
                    lane_we     = 4'b1111;
                    wdata_lanes = wdata;
                    rdata_ext   = rword;
                end
            end
            default: err = 1'b1;
        endcase
    end

endmodule

// File: rtl/data_mem_responder.sv
// Data-memory responder: IDLE -> WAIT (optional) -> ACCESS -> RESP, one request in flight.
// Optional misalignment trapping is selected by DMEM_MISALIGN_TRAP_EN (see mem_lane_align).
module data_mem_responder
    import mem_defs::*;
#(
    parameter int ADDR_W      = 10,
    parameter int WAIT_CYCLES = 1
) (
    input  logic                 clockCPU,
    input  logic                 reset,
    data_mem_responder_if.slave  bus,
    output state_t               dbg_state
);

    localparam logic [3:0] WAIT_LOAD = 4'((WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0);

    state_t             state;
    state_t             state_nxt;
    logic [3:0]         wait_cnt;
    logic               wr_q;
    logic [ADDR_W+1:0]  addr_q;
    logic [31:0]        wdata_q;
    logic [2:0]         size_q;
    logic [31:0]        rdata_q;
    logic               err_q;
    logic               accept;

    logic [31:0]        mem [2**ADDR_W];
    logic [ADDR_W-1:0]  word_idx;
    logic [3:0]         lane_we;
    logic [31:0]        wdata_lanes;
    logic [31:0]        rdata_ext;
    logic               align_err;

    assign word_idx  = addr_q[ADDR_W+1:2];
    assign dbg_state = state;
    assign accept    = (state == ST_IDLE) && bus.iReq;

    mem_lane_align u_align (
        .size        (size_q),
        .addr_lo     (addr_q[1:0]),
        .wdata       (wdata_q),
        .rword       (mem[word_idx]),
        .lane_we     (lane_we),
        .wdata_lanes (wdata_lanes),
        .rdata_ext   (rdata_ext),
        .err         (align_err)
    );

    always_comb begin
        state_nxt   = state;
        bus.oReady  = 1'b0;
        bus.oRValid = 1'b0;
        bus.oBusy   = 1'b1;
        bus.oRData  = rdata_q;
        bus.oErr    = err_q;
        case (state)
            ST_IDLE: begin
                bus.oReady = 1'b1;
                bus.oBusy  = 1'b0;
                if (bus.iReq) state_nxt = (WAIT_CYCLES > 0) ? ST_WAIT : ST_ACCESS;
            end
            ST_WAIT:   if (wait_cnt == 4'd0) state_nxt = ST_ACCESS;
            ST_ACCESS: state_nxt = ST_RESP;
            ST_RESP: begin
                bus.oRValid = 1'b1;
                state_nxt   = ST_IDLE;
            end
            default:   state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clockCPU) begin
        if (reset) begin
            state    <= ST_IDLE;
            wait_cnt <= 4'd0;
            rdata_q  <= 32'h0;
            err_q    <= 1'b0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                wait_cnt <= WAIT_LOAD;
            end else if (state == ST_WAIT && wait_cnt != 4'd0) begin
                wait_cnt <= wait_cnt - 4'd1;
            end
            // Stores and faulting accesses always answer with zero data.
            if (state == ST_ACCESS) begin
                rdata_q <= (wr_q || align_err) ? 32'h0 : rdata_ext;
                err_q   <= align_err;
            end
        end
    end

    // Request payload is captured at acceptance so the master may drop it immediately.
    always_ff @(posedge clockCPU) begin
        if (!reset && accept) begin
            wr_q    <= bus.iWrite;
            addr_q  <= bus.iAddr[ADDR_W+1:0];
            wdata_q <= bus.iWData;
            size_q  <= bus.iSize;
        end
    end

    // Storage is never reset; a reset during ACCESS abandons the store before it commits.
    always_ff @(posedge clockCPU) begin
        if (!reset && state == ST_ACCESS && wr_q) begin
            for (int i = 0; i < 4; i++) begin
                if (lane_we[i]) mem[word_idx][8*i +: 8] <= wdata_lanes[8*i +: 8];
            end
        end
    end

endmodule

// File: tb/tb_data_mem_responder.sv
// Self-checking bench for data_mem_responder with an expected-response scoreboard.
module tb_data_mem_responder;
  import mem_defs::*;

  localparam int ADDR_W      = 10;
  localparam int WAIT_CYCLES = 1;
  localparam int LATENCY     = WAIT_CYCLES + 2;
  localparam int PERIOD      = WAIT_CYCLES + 3;

  logic   clk;
  logic   reset;
  state_t dut_state;

  data_mem_responder_if bus ();

  data_mem_responder #(
    .ADDR_W      (ADDR_W),
    .WAIT_CYCLES (WAIT_CYCLES)
  ) dut (
    .clockCPU  (clk),
    .reset     (reset),
    .bus       (bus),
    .dbg_state (dut_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // scoreboard
  logic [31:0] exp_q[$];
  logic        err_q[$];
  int          acc_q[$];
  int          acc_cycles[$];
  int          acc_count = 0;
  int          checks = 0;
  int          errors = 0;

  logic [31:0] cur_exp_d;
  logic        cur_exp_e;
  bit          cur_expect;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  // monitor: responses and acceptances are sampled on the falling edge
  always @(negedge clk) begin
    if (bus.oRValid) begin
      if (exp_q.size() == 0) begin
        check("unexpected_rvalid", 32'd1, 32'd0);
      end else begin
        logic [31:0] ed;
        logic        ee;
        int          ac;
        ed = exp_q.pop_front();
        ee = err_q.pop_front();
        ac = acc_q.pop_front();
        check("rdata", bus.oRData, ed);
        check("rerr", 32'(bus.oErr), 32'(ee));
        check("latency", 32'(cyc - ac), 32'(LATENCY));
        check("resp_busy_ready", {30'h0, bus.oBusy, bus.oReady}, 32'b10);
      end
    end
    if (bus.iReq && bus.oReady && !reset) begin
      acc_count++;
      acc_cycles.push_back(cyc);
      if (cur_expect) begin
        exp_q.push_back(cur_exp_d);
        err_q.push_back(cur_exp_e);
        acc_q.push_back(cyc);
      end
    end
  end

  task automatic wait_drain();
    int t = 0;
    while (exp_q.size() != 0 && t < 50) begin
      @(posedge clk);
      t++;
    end
    if (exp_q.size() != 0) begin
      check("resp_timeout", 32'd0, 32'd1);
      exp_q.delete();
      err_q.delete();
      acc_q.delete();
    end
    @(posedge clk);
    #1;
  endtask

  // driver: returns at #1 after the accepting edge, optionally after the response
  task automatic do_req(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [2:0] size, input logic [31:0] exp_d, input logic exp_e,
                        input bit expect_rsp);
    int n0;
    int t;
    n0 = acc_count;
    @(posedge clk);
    #1;
    cur_exp_d  = exp_d;
    cur_exp_e  = exp_e;
    cur_expect = expect_rsp;
    bus.iWrite = wr;
    bus.iAddr  = addr;
    bus.iWData = wdata;
    bus.iSize  = size;
    bus.iReq   = 1'b1;
    t = 0;
    while (acc_count == n0 && t < 50) begin
      @(posedge clk);
      t++;
    end
    if (acc_count == n0) check("accept_timeout", 32'd0, 32'd1);
    #1;
    bus.iReq   = 1'b0;
    bus.iAddr  = $urandom;
    bus.iWData = $urandom;
    bus.iWrite = 1'($urandom_range(0, 1));
    bus.iSize  = 3'($urandom_range(0, 7));
    if (expect_rsp) wait_drain();
  endtask

  initial begin
    int t;
    int n0;
    reset      = 1'b1;
    bus.iReq   = 1'b0;
    bus.iWrite = 1'b0;
    bus.iAddr  = 32'h0;
    bus.iWData = 32'h0;
    bus.iSize  = SZ_W;
    cur_expect = 1'b0;
    cur_exp_d  = 32'h0;
    cur_exp_e  = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_state", 32'(dut_state), 32'(ST_IDLE));
    check("rst_ready", 32'(bus.oReady), 32'd1);
    check("rst_rvalid", 32'(bus.oRValid), 32'd0);
    check("rst_rdata", bus.oRData, 32'h0);
    check("rst_err", 32'(bus.oErr), 32'd0);
    check("rst_busy", 32'(bus.oBusy), 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;

    // word, byte and half accesses around 0x40
    do_req(1'b1, 32'h40, 32'hDEADBEEF, SZ_W, 32'h0, 1'b0, 1'b1);
    do_req(1'b0, 32'h40, 32'h0, SZ_W, 32'hDEADBEEF, 1'b0, 1'b1);
    do_req(1'b1, 32'h41, 32'h0000007F, SZ_B, 32'h0, 1'b0, 1'b1);
    do_req(1'b0, 32'h41, 32'h0, SZ_B, 32'h0000007F, 1'b0, 1'b1);
    do_req(1'b0, 32'h43, 32'h0, SZ_BU, 32'h000000DE, 1'b0, 1'b1);
    do_req(1'b0, 32'h40, 32'h0, SZ_W, 32'hDEAD7FEF, 1'b0, 1'b1);
    do_req(1'b1, 32'h42, 32'hFFFF8001, SZ_H, 32'h0, 1'b0, 1'b1);
    do_req(1'b0, 32'h42, 32'h0, SZ_H, 32'hFFFF8001, 1'b0, 1'b1);
    do_req(1'b0, 32'h42, 32'h0, SZ_HU, 32'h00008001, 1'b0, 1'b1);
    do_req(1'b0, 32'h40, 32'h0, SZ_W, 32'h80017FEF, 1'b0, 1'b1);
    // high address bits wrap onto the same word
    do_req(1'b0, 32'h40 + (32'h1 << (ADDR_W + 2)), 32'h0, SZ_B, 32'hFFFFFFEF, 1'b0, 1'b1);

    // illegal size: error, no write
    do_req(1'b1, 32'h40, 32'h12345678, 3'b011, 32'h0, 1'b1, 1'b1);
    do_req(1'b0, 32'h40, 32'h0, 3'b110, 32'h0, 1'b1, 1'b1);
    do_req(1'b0, 32'h40, 32'h0, SZ_W, 32'h80017FEF, 1'b0, 1'b1);

    // reset during WAIT abandons the store and its response
    do_req(1'b1, 32'h80, 32'h11223344, SZ_W, 32'h0, 1'b0, 1'b1);
    do_req(1'b1, 32'h80, 32'hCAFEBABE, SZ_W, 32'h0, 1'b0, 1'b0);
    check("abandon_in_wait", 32'(dut_state), 32'(ST_WAIT));
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    check("abandon_state", 32'(dut_state), 32'(ST_IDLE));
    check("abandon_busy", 32'(bus.oBusy), 32'd0);
    repeat (6) @(posedge clk);
    do_req(1'b0, 32'h80, 32'h0, SZ_W, 32'h11223344, 1'b0, 1'b1);

    // misaligned word load
`ifdef DMEM_MISALIGN_TRAP_EN
    do_req(1'b0, 32'h42, 32'h0, SZ_W, 32'h0, 1'b1, 1'b1);
`else
    do_req(1'b0, 32'h42, 32'h0, SZ_W, 32'h80017FEF, 1'b0, 1'b1);
`endif

    // iReq held high: next acceptance only once back in IDLE
    @(posedge clk);
    #1;
    cur_exp_d  = 32'h80017FEF;
    cur_exp_e  = 1'b0;
    cur_expect = 1'b1;
    bus.iWrite = 1'b0;
    bus.iAddr  = 32'h40;
    bus.iSize  = SZ_W;
    n0         = acc_count;
    bus.iReq   = 1'b1;
    t = 0;
    while (acc_count < n0 + 2 && t < 50) begin
      @(posedge clk);
      t++;
    end
    #1;
    bus.iReq = 1'b0;
    if (acc_count < n0 + 2) begin
      check("held_accept_timeout", 32'd0, 32'd1);
    end else begin
      check("held_spacing", 32'(acc_cycles[acc_cycles.size()-1] - acc_cycles[acc_cycles.size()-2]),
            32'(PERIOD));
    end
    wait_drain();
    repeat (4) @(posedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
